idiv_bus_ctrl: RTL and testbench

Memory-mapped front end that sits upstream of IDivider and connects it to the CPU I/O bus. It latches the dividend and divisor written by software and sequences the divider's write_a, start and flush inputs. It watches ready, captures quotient and remainder into result registers, and stalls bus reads until a result is available. It also short-circuits divide-by-zero and guards against a hung divider with a timeout.

---
 rtl/idiv_bus_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_idiv_bus_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idiv_bus_ctrl.sv
// Bus front end for the iterative divider: latches operands, sequences write_a/start/flush,
// captures results and stalls result reads while a division is in flight.
module idiv_bus_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       bus_addr,
  input  logic [WIDTH-1:0] bus_data,
  input  logic             bus_we,
  input  logic             bus_start,
  output logic [WIDTH-1:0] bus_q,
  output logic             bus_done,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_write_a,
  output logic             div_start,
  output logic             div_signed,
  output logic             div_flush,
  input  logic             div_ready,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOADA, START, FLUSH, WAIT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d, divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [WIDTH-1:0] bus_q_q, bus_q_d, pend_data_q, pend_data_d;
  logic [1:0]       pend_addr_q, pend_addr_d;
  logic             pend_q, pend_d, pend_we_q, pend_we_d;
  logic             busy_q, busy_d, div0_q, div0_d, tmo_q, tmo_d, signed_q, signed_d;
  logic             bus_done_q, bus_done_d, wra_q, wra_d, start_q, start_d, flush_q, flush_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Transaction under service: a held one takes priority over the live bus.
  logic             t_v, t_we, nonstall, restart, ready_ok, timeout;
  logic [1:0]       t_addr;
  logic [WIDTH-1:0] t_data, rd_data, status;

  always_comb begin
    t_v    = pend_q | bus_start;
    t_we   = pend_q ? pend_we_q   : bus_we;
    t_addr = pend_q ? pend_addr_q : bus_addr;
    t_data = pend_q ? pend_data_q : bus_data;
    status = '0;
    status[2:0] = {tmo_q, div0_q, busy_q};
    case (t_addr)
      2'd0:    rd_data = quot_q;
      2'd1:    rd_data = rem_q;
      2'd2:    rd_data = status;
      default: rd_data = '0;
    endcase
    nonstall = t_we ? (t_addr == 2'd3) : t_addr[1];
    restart  = t_we && (t_addr == 2'd1 || t_addr == 2'd2);
  end

  // The divider may still show the previous ready during the start cycle and the one after.
  assign ready_ok = div_ready && (cnt_q >= CW'(2));
  assign timeout  = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    busy_d      = busy_q;
    div0_d      = div0_q;
    tmo_d       = tmo_q;
    signed_d    = signed_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_we_d   = pend_we_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    bus_q_d     = '0;
    bus_done_d  = 1'b0;
    wra_d       = 1'b0;
    start_d     = 1'b0;
    flush_d     = 1'b0;

    if (bus_start && !pend_q) begin
      pend_d      = 1'b1;
      pend_we_d   = bus_we;
      pend_addr_d = bus_addr;
      pend_data_d = bus_data;
    end

    case (state_q)
      IDLE, LOADA, FLUSH: begin
        if (state_q == LOADA) state_d = IDLE;
        if (t_v) begin
          pend_d     = 1'b0;
          bus_done_d = 1'b1;
          if (!t_we) begin
            bus_q_d = rd_data;
          end else if (t_addr == 2'd0) begin
            dividend_d = t_data;
            wra_d      = 1'b1;
            state_d    = LOADA;
          end else if (t_addr == 2'd3) begin
            div0_d = 1'b0;
            tmo_d  = 1'b0;
          end else if (t_data == '0) begin
            quot_d  = '1;
            rem_d   = dividend_q;
            div0_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            divisor_d = t_data;
            signed_d  = (t_addr == 2'd1);
            start_d   = 1'b1;
            busy_d    = 1'b1;
            div0_d    = 1'b0;
            cnt_d     = '0;
            state_d   = (state_q == FLUSH) ? START : WAIT;
          end
        end
      end
      START: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (t_v && restart) begin
          flush_d = 1'b1;
          state_d = FLUSH;
        end else begin
          if (t_v && nonstall) begin
            pend_d     = 1'b0;
            bus_done_d = 1'b1;
            if (t_we) begin
              div0_d = 1'b0;
              tmo_d  = 1'b0;
            end else begin
              bus_q_d = rd_data;
            end
          end
          if (ready_ok || timeout) begin
            quot_d  = ready_ok ? div_quotient  : '0;
            rem_d   = ready_ok ? div_remainder : '0;
            busy_d  = 1'b0;
            state_d = IDLE;
            if (!ready_ok) begin
              tmo_d   = 1'b1;
              flush_d = 1'b1;
            end
            // A stalled result read completes with the freshly captured value.
            if (pend_q && !pend_we_q) begin
              pend_d     = 1'b0;
              bus_done_d = 1'b1;
              bus_q_d    = pend_addr_q[0] ? rem_d : quot_d;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      busy_q      <= 1'b0;
      div0_q      <= 1'b0;
      tmo_q       <= 1'b0;
      signed_q    <= 1'b0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      bus_q_q     <= '0;
      bus_done_q  <= 1'b0;
      wra_q       <= 1'b0;
      start_q     <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      busy_q      <= busy_d;
      div0_q      <= div0_d;
      tmo_q       <= tmo_d;
      signed_q    <= signed_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_we_q   <= pend_we_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      bus_q_q     <= bus_q_d;
      bus_done_q  <= bus_done_d;
      wra_q       <= wra_d;
      start_q     <= start_d;
      flush_q     <= flush_d;
    end
  end

  assign bus_q       = bus_q_q;
  assign bus_done    = bus_done_q;
  assign div_a       = dividend_q;
  assign div_b       = divisor_q;
  assign div_write_a = wra_q;
  assign div_start   = start_q;
  assign div_signed  = signed_q;
  assign div_flush   = flush_q;
endmodule

// File: tb/tb_idiv_bus_ctrl.sv
// Directed bench for idiv_bus_ctrl with a behavioural divider stub (configurable latency / hang).
module tb_idiv_bus_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   bus_addr = '0;
  logic [W-1:0] bus_data = '0;
  logic         bus_we = 1'b0;
  logic         bus_start = 1'b0;
  logic [W-1:0] bus_q, div_a, div_b;
  logic         bus_done, div_write_a, div_start, div_signed, div_flush;
  logic         div_ready;
  logic [W-1:0] div_quotient, div_remainder;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_wra = 0, n_start = 0, n_flush = 0;
  int c_wra = 0, c_start = 0, c_flush = 0;
  int issue_cyc = 0;
  int lat = 0;
  logic [W-1:0] rd;
  int stub_lat = 3;
  bit hang = 1'b0;

  idiv_bus_ctrl #(.WIDTH(W), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we), .bus_start(bus_start),
    .bus_q(bus_q), .bus_done(bus_done),
    .div_a(div_a), .div_b(div_b), .div_write_a(div_write_a), .div_start(div_start),
    .div_signed(div_signed), .div_flush(div_flush),
    .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  // Cycle stamps of divider strobes (cycle N = value of cyc during that cycle).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_write_a) begin n_wra   <= n_wra + 1;   c_wra   <= cyc; end
    if (div_start)   begin n_start <= n_start + 1; c_start <= cyc; end
    if (div_flush)   begin n_flush <= n_flush + 1; c_flush <= cyc; end
  end

  // Divider stub: ready stays stale for one cycle after start, then rises after stub_lat cycles.
  logic [W-1:0] st_a, st_q, st_r;
  int  st_cnt;
  bit  st_drop;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st_a <= '0; st_q <= '0; st_r <= '0; st_cnt <= 0; st_drop <= 1'b0;
      div_ready <= 1'b0; div_quotient <= '0; div_remainder <= '0;
    end else begin
      if (div_write_a) st_a <= div_a;
      if (div_flush) begin
        st_cnt <= 0; st_drop <= 1'b0; div_ready <= 1'b0;
      end else if (div_start) begin
        st_cnt  <= stub_lat;
        st_drop <= 1'b1;
        if (div_signed) begin
          st_q <= $signed(st_a) / $signed(div_b);
          st_r <= $signed(st_a) % $signed(div_b);
        end else begin
          st_q <= st_a / div_b;
          st_r <= st_a % div_b;
        end
      end else begin
        if (st_drop) begin
          st_drop <= 1'b0; div_ready <= 1'b0;
          div_quotient <= 32'hBAD0_BAD0; div_remainder <= 32'hBAD0_BAD0;
        end
        if (st_cnt != 0) begin
          st_cnt <= st_cnt - 1;
          if (st_cnt == 1 && !hang) begin
            div_ready <= 1'b1; div_quotient <= st_q; div_remainder <= st_r;
          end
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one bus transaction at a negedge; return at the negedge where bus_done is seen.
  task automatic xfer(input logic we, input logic [1:0] addr, input logic [W-1:0] data);
    int  n;
    bit  seen;
    bus_we = we; bus_addr = addr; bus_data = data; bus_start = 1'b1;
    issue_cyc = cyc;
    @(negedge clk);
    bus_start = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_data = '0;
    n = 1; seen = 1'b0; rd = '0;
    while (!seen && n < 300) begin
      if (bus_done) begin
        seen = 1'b1; rd = bus_q;
      end else begin
        @(negedge clk); n++;
      end
    end
    lat = n;
    $display("bus we=%0d addr=%0d data=0x%08h -> q=0x%08h latency=%0d", we, addr, data, rd, lat);
    check_eq("done_seen", {31'b0, seen}, 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [W-1:0] exp);
    xfer(1'b0, addr, '0);
    check_eq(tag, rd, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, t0, s0, f0, k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_strobes", {27'b0, bus_done, div_write_a, div_start, div_flush, div_signed}, '0);
    check_eq("rst_bus_q", bus_q, '0);
    check_eq("rst_div_a", div_a, '0);
    rst = 1'b0;
    @(negedge clk);
    rd_chk("rst_status", 2'd2, 32'd0);

    // 17 / 3 signed
    xfer(1'b1, 2'd0, 32'd17);
    w0 = issue_cyc;
    check_eq("wra_lat", lat, 32'd1);
    check_eq("div_a", div_a, 32'd17);
    s0 = n_start;
    xfer(1'b1, 2'd1, 32'd3);
    t0 = issue_cyc;
    check_eq("start_lat", lat, 32'd1);
    check_eq("div_signed_1", {31'b0, div_signed}, 32'd1);
    check_eq("div_b", div_b, 32'd3);
    rd_chk("status_busy", 2'd2, 32'd1);
    check_eq("wra_cyc", c_wra, w0 + 1);
    check_eq("wra_cnt", n_wra, 32'd1);
    check_eq("start_cyc", c_start, t0 + 1);
    check_eq("start_cnt", n_start - s0, 32'd1);
    repeat (8) @(negedge clk);
    rd_chk("status_idle", 2'd2, 32'd0);
    rd_chk("q_17_3", 2'd0, 32'd5);
    rd_chk("r_17_3", 2'd1, 32'd2);

    // -17 / 3 signed
    xfer(1'b1, 2'd0, 32'hFFFF_FFEF);
    xfer(1'b1, 2'd1, 32'd3);
    repeat (8) @(negedge clk);
    rd_chk("q_m17_3", 2'd0, 32'hFFFF_FFFB);
    rd_chk("r_m17_3", 2'd1, 32'hFFFF_FFFE);

    // 0xFFFFFFF0 / 16 unsigned
    xfer(1'b1, 2'd0, 32'hFFFF_FFF0);
    xfer(1'b1, 2'd2, 32'd16);
    check_eq("div_signed_0", {31'b0, div_signed}, 32'd0);
    repeat (8) @(negedge clk);
    rd_chk("q_unsigned", 2'd0, 32'h0FFF_FFFF);
    rd_chk("r_unsigned", 2'd1, 32'd0);

    // divide by zero short-circuit
    s0 = n_start;
    xfer(1'b1, 2'd0, 32'd42);
    xfer(1'b1, 2'd1, 32'd0);
    repeat (2) @(negedge clk);
    check_eq("div0_no_start", n_start - s0, 32'd0);
    rd_chk("q_div0", 2'd0, 32'hFFFF_FFFF);
    rd_chk("r_div0", 2'd1, 32'd42);
    rd_chk("status_div0", 2'd2, 32'd2);
    xfer(1'b1, 2'd3, 32'd0);
    rd_chk("status_clr", 2'd2, 32'd0);
    rd_chk("read_addr3", 2'd3, 32'd0);

    // result read stalls until the result latch
    stub_lat = 6;
    xfer(1'b1, 2'd0, 32'd100);
    xfer(1'b1, 2'd2, 32'd7);
    xfer(1'b0, 2'd0, '0);
    check_eq("stall_lat", lat, 32'd8);
    check_eq("stall_q", rd, 32'd14);
    rd_chk("stall_r", 2'd1, 32'd2);

    // restart while busy
    stub_lat = 20;
    xfer(1'b1, 2'd0, 32'd50);
    xfer(1'b1, 2'd1, 32'd5);
    repeat (5) @(negedge clk);
    stub_lat = 3;
    f0 = n_flush;
    s0 = n_start;
    xfer(1'b1, 2'd2, 32'd8);
    t0 = issue_cyc;
    check_eq("restart_lat", lat, 32'd2);
    @(negedge clk);
    check_eq("restart_flush_cnt", n_flush - f0, 32'd1);
    check_eq("restart_flush_cyc", c_flush, t0 + 1);
    check_eq("restart_start_cnt", n_start - s0, 32'd1);
    check_eq("restart_start_cyc", c_start, t0 + 2);
    repeat (8) @(negedge clk);
    rd_chk("q_restart", 2'd0, 32'd6);
    rd_chk("r_restart", 2'd1, 32'd2);

    // hung divider -> timeout
    hang = 1'b1;
    xfer(1'b1, 2'd0, 32'd9);
    xfer(1'b1, 2'd1, 32'd3);
    t0 = issue_cyc;
    f0 = n_flush;
    k = 0;
    while (n_flush == f0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("tmo_flush_cnt", n_flush - f0, 32'd1);
    check_eq("tmo_flush_dist", c_flush - (t0 + 1), 32'd64);
    rd_chk("status_tmo", 2'd2, 32'd4);
    rd_chk("q_tmo", 2'd0, 32'd0);

    // asynchronous reset mid-WAIT
    xfer(1'b1, 2'd1, 32'd3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("arst_strobes", {27'b0, bus_done, div_write_a, div_start, div_flush, div_signed}, '0);
    check_eq("arst_div_b", div_b, '0);
    check_eq("arst_div_a", div_a, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_chk("arst_status", 2'd2, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
